// File: rtl/fsm_table_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsm_table_pkg
// Description : Shared types and field constants for the programmable FSM engine
// Revision    : 1.0 - initial release
// ============================================================================
package fsm_table_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} ctrl_t;
    typedef enum logic [1:0] {E_NONE, E_NOT_LOADED, E_ILLEGAL} err_t;

    localparam int ADDR_W   = 4;
    localparam int ENTRY_W  = 6;
    localparam int STATE_W  = 3;
    localparam int DEPTH    = 1 << ADDR_W;

    // Entry layout: {next[2:0], out[2:0]}
    localparam int NEXT_MSB = 5;
    localparam int NEXT_LSB = 3;
    localparam int OUT_MSB  = 2;
    localparam int OUT_LSB  = 0;

endpackage
`default_nettype wire

// File: rtl/fsm_table_mem.sv
`default_nettype none
// ============================================================================
// Module      : fsm_table_mem
// Description : Transition table register file, sync write / async read, no reset
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_table_mem
    import fsm_table_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fsm_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fsm_table_ctrl
// Description : Table-programmed 3-bit state machine with load/run/error supervision
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_table_ctrl
    import fsm_table_pkg::*;
#(
    parameter logic [STATE_W-1:0] RST_STATE  = 3'd2,
    parameter logic [7:0]         LEGAL_MASK = 8'hF4,
    parameter int                 CNT_W      = 8
) (
    input  logic               clk,
    input  logic               res,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [ENTRY_W-1:0] cfg_data,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic               step_en,
    input  logic               a,
    output logic [STATE_W-1:0] st,
    output logic [STATE_W-1:0] sd,
    output logic               loaded,
    output logic               busy,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [CNT_W-1:0]   step_cnt
);

    ctrl_t              r_ctrl;
    err_t               r_err;
    logic [STATE_W-1:0] r_st;
    logic [STATE_W-1:0] r_sd;
    logic [CNT_W-1:0]   r_cnt;
    logic [DEPTH-1:0]   r_mask;
    logic               r_loaded;

    logic               w_wr;
    logic [DEPTH-1:0]   w_mask_nxt;
    logic [ENTRY_W-1:0] w_entry;
    logic [STATE_W-1:0] w_next;
    logic [STATE_W-1:0] w_out;

    assign cfg_ready  = (r_ctrl == IDLE) || (r_ctrl == LOAD);
    assign w_wr       = cfg_valid && cfg_ready;
    assign w_mask_nxt = r_mask | (w_wr ? ({{(DEPTH-1){1'b0}}, 1'b1} << cfg_addr) : '0);
    assign w_next     = w_entry[NEXT_MSB:NEXT_LSB];
    assign w_out      = w_entry[OUT_MSB:OUT_LSB];

    fsm_table_mem u_mem (
        .clk   (clk),
        .we    (w_wr),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr ({a, r_st}),
        .rdata (w_entry)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_ctrl   <= IDLE;
            r_err    <= E_NONE;
            r_st     <= RST_STATE;
            r_sd     <= '0;
            r_cnt    <= '0;
            r_mask   <= '0;
            r_loaded <= 1'b0;
        end else begin
            r_mask   <= w_mask_nxt;
            r_loaded <= &w_mask_nxt;
            unique case (r_ctrl)
                IDLE, LOAD: begin
                    if (stop) begin
                        r_ctrl <= IDLE;
                    end else if (start) begin
                        // loaded is the pre-edge value: a same-cycle final write does not count
                        if (r_loaded) begin
                            r_ctrl <= RUN;
                            r_st   <= RST_STATE;
                            r_sd   <= '0;
                            r_cnt  <= '0;
                        end else begin
                            r_ctrl <= ERR;
                            r_err  <= E_NOT_LOADED;
                        end
                    end else if (w_wr) begin
                        r_ctrl <= LOAD;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_ctrl <= IDLE;
                    end else if (step_en) begin
                        if (LEGAL_MASK[w_next]) begin
                            r_st <= w_next;
                            r_sd <= w_out;
                            if (r_cnt != {CNT_W{1'b1}}) begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else begin
                            r_ctrl <= ERR;
                            r_err  <= E_ILLEGAL;
                        end
                    end
                end
                ERR: begin
                    if (clear) begin
                        r_ctrl <= IDLE;
                        r_err  <= E_NONE;
                    end
                end
            endcase
        end
    end

    assign st       = r_st;
    assign sd       = r_sd;
    assign step_cnt = r_cnt;
    assign loaded   = r_loaded;
    assign busy     = (r_ctrl == RUN);
    assign err      = (r_ctrl == ERR);
    assign err_code = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fsm_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_table_ctrl
// Description : Directed vector bench for fsm_table_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_table_ctrl;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_addr = '0;
    logic [5:0] cfg_data = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       step_en = 1'b0;
    logic       a = 1'b0;
    logic [2:0] st;
    logic [2:0] sd;
    logic       loaded;
    logic       busy;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] step_cnt;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic       start;
        logic       a;
        logic       en;
        logic       stop;
        logic [2:0] st;
        logic [2:0] sd;
        int         cnt;
        logic       busy;
    } vec_t;

    vec_t vecs[16];

    fsm_table_ctrl dut (
        .clk       (clk),
        .res       (res),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .step_en   (step_en),
        .a         (a),
        .st        (st),
        .sd        (sd),
        .loaded    (loaded),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code),
        .step_cnt  (step_cnt)
    );

    always #5 clk = ~clk;

    // Reference table: out = current state, next from the hand-written transition list
    function automatic logic [5:0] ent(input int addr);
        logic [2:0] s;
        logic       ai;
        logic [2:0] n;
        s  = addr[2:0];
        ai = addr[3];
        case (s)
            3'd2:    n = 3'd6;
            3'd4:    n = ai ? 3'd6 : 3'd2;
            3'd5:    n = 3'd4;
            3'd6:    n = ai ? 3'd7 : 3'd5;
            3'd7:    n = 3'd5;
            default: n = 3'd2;
        endcase
        return {n, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic wr(input int addr, input logic [5:0] data);
        cfg_addr  = addr[3:0];
        cfg_data  = data;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic load_n(input int n);
        for (int i = 0; i < n; i++) wr(i, ent(i));
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic step(input logic ai);
        a = ai; step_en = 1'b1; tick(); step_en = 1'b0;
    endtask

    initial begin
        // start, a, en, stop -> st, sd, cnt, busy
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 3'd2, 1, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 3'd2, 1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd6, 2, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 3'd5, 3, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 3'd4, 4, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 3'd4, 4, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 3'd2, 1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 3'd6, 2, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 3'd7, 3, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 3'd5, 4, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 3'd4, 5, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 3'd6, 6, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 3'd7, 7, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 3'd7, 7, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd7, 7, 1'b0};

        // Reset state
        tick(); tick();
        res = 1'b0;
        chk("rst_st", st, 2);
        chk("rst_sd", sd, 0);
        chk("rst_cnt", step_cnt, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_errcode", err_code, 0);
        chk("rst_ready", cfg_ready, 1);

        // Partial load then start -> NOT_LOADED
        load_n(15);
        chk("ld15_ready", cfg_ready, 1);
        chk("ld15_loaded", loaded, 0);
        pulse_start();
        chk("nl_err", err, 1);
        chk("nl_code", err_code, 1);
        chk("nl_busy", busy, 0);
        chk("nl_ready", cfg_ready, 0);
        pulse_clear();
        chk("nl_clr_err", err, 0);
        chk("nl_clr_code", err_code, 0);
        chk("nl_clr_ready", cfg_ready, 1);
        wr(15, ent(15));
        tick();
        chk("ld16_loaded", loaded, 1);
        pulse_start();
        chk("run_busy", busy, 1);
        chk("run_st", st, 2);

        // Table-driven run sequences
        for (int i = 0; i < 16; i++) begin
            start = vecs[i].start; a = vecs[i].a;
            step_en = vecs[i].en;  stop = vecs[i].stop;
            tick();
            start = 1'b0; step_en = 1'b0; stop = 1'b0;
            chk($sformatf("vec%0d_st", i), st, vecs[i].st);
            chk($sformatf("vec%0d_sd", i), sd, vecs[i].sd);
            chk($sformatf("vec%0d_cnt", i), step_cnt, vecs[i].cnt);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
        end

        // cfg_valid held during RUN must stall and leave the table intact
        pulse_start();
        cfg_addr = 4'h2; cfg_data = {3'd3, 3'd2}; cfg_valid = 1'b1;
        tick();
        chk("stall_ready0", cfg_ready, 0);
        tick();
        chk("stall_ready1", cfg_ready, 0);
        cfg_valid = 1'b0;
        pulse_stop();
        pulse_start();
        step(1'b0);
        chk("stall_tbl_st", st, 6);
        chk("stall_tbl_err", err, 0);
        pulse_stop();

        // Illegal next state
        wr(2, {3'd3, 3'd2});
        pulse_start();
        chk("ill_busy_pre", busy, 1);
        step(1'b0);
        chk("ill_err", err, 1);
        chk("ill_code", err_code, 2);
        chk("ill_st", st, 2);
        chk("ill_sd", sd, 0);
        chk("ill_cnt", step_cnt, 0);
        pulse_start();
        chk("ill_start_ign", err, 1);
        pulse_stop();
        chk("ill_stop_ign", err, 1);
        chk("ill_stop_code", err_code, 2);
        pulse_clear();
        chk("ill_clr_err", err, 0);
        chk("ill_clr_code", err_code, 0);
        chk("ill_clr_loaded", loaded, 1);
        wr(2, ent(2));

        // Start coincident with the final write -> NOT_LOADED, write still lands
        res = 1'b1; tick(); res = 1'b0;
        load_n(15);
        cfg_addr = 4'hF; cfg_data = ent(15); cfg_valid = 1'b1; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        chk("co_err", err, 1);
        chk("co_code", err_code, 1);
        pulse_clear();
        chk("co_loaded", loaded, 1);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_err", err, 0);

        // Reset mid-run after 3 steps
        pulse_start();
        for (int i = 0; i < 3; i++) step(1'b0);
        chk("mr_st_pre", st, 4);
        chk("mr_cnt_pre", step_cnt, 3);
        res = 1'b1; tick(); res = 1'b0;
        chk("mr_st", st, 2);
        chk("mr_sd", sd, 0);
        chk("mr_cnt", step_cnt, 0);
        chk("mr_loaded", loaded, 0);
        chk("mr_busy", busy, 0);

        // Step counter saturation: 257 steps of the 4-cycle loop 2->6->5->4->2
        load_n(16);
        tick();
        pulse_start();
        a = 1'b0; step_en = 1'b1;
        for (int i = 0; i < 257; i++) tick();
        step_en = 1'b0;
        chk("sat_cnt", step_cnt, 255);
        chk("sat_st", st, 6);
        chk("sat_busy", busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fsm_table_ctrl.md
Name: fsm_table_ctrl

Overview:
- Loads a 16x6 next-state/output transition table over a valid/ready config port, then runs the programmed 3-bit state machine one step per enabled cycle.
- Detects illegal next states.
- Replaces hand-coded FSM variants with one programmable engine plus run/stop/error supervision.

Parameters:
RST_STATE, 3'd2, state entered on reset and on every start
LEGAL_MASK, 8'hF4, bit n set = state n legal (default: 2,4,5,6,7)
CNT_W, 8, width of step counter

Ports:
clk  in  1  clock, all logic on rising edge
res  in  1  synchronous active-high reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when valid&ready
cfg_addr  in  4  table address {a, state[2:0]}
cfg_data  in  6  entry {next[2:0], out[2:0]}
start  in  1  begin run from RST_STATE
stop  in  1  end run, return to IDLE
clear  in  1  leave ERR
step_en  in  1  advance machine this cycle (RUN only)
a  in  1  machine input
st  out  3  current machine state
sd  out  3  registered output field of last taken transition
loaded  out  1  all 16 entries written since reset
busy  out  1  ctrl == RUN
err  out  1  ctrl == ERR
err_code  out  2  0 none, 1 NOT_LOADED, 2 ILLEGAL_STATE
step_cnt  out  CNT_W  steps taken in current run, saturating

Behaviour:
- Reset (res=1 at edge): ctrl=IDLE, st=RST_STATE, sd=0, step_cnt=0, err_code=0, written-mask=0 (so loaded=0). Table contents not reset.
- Controller states: IDLE, LOAD, RUN, ERR.
- cfg_ready=1 in IDLE and LOAD, 0 in RUN and ERR (combinational from ctrl).
- Write on valid&ready: table[cfg_addr]<=cfg_data, mask[cfg_addr]<=1. IDLE→LOAD on the write.
- Rewrites allowed; last write wins.
- loaded = &mask, registered; it rises the cycle after the 16th distinct address is written.
- start in IDLE/LOAD:
  - if loaded=1: →RUN; st<=RST_STATE, sd<=0, step_cnt<=0.
  - if loaded=0: →ERR, err_code<=1.
  - loaded is sampled as the current registered value, so start in the same cycle as the final write goes to ERR.
- A cfg write coincident with start is still performed.
- stop has priority over start in the same cycle: stay in/return to IDLE.
- RUN, step_en=1, stop=0:
  - entry=table[{a,st}].
  - If LEGAL_MASK[entry.next]=1: st<=entry.next, sd<=entry.out, step_cnt<=min(step_cnt+1, max).
  - Else: →ERR, err_code<=2, st/sd/step_cnt hold.
- RUN, step_en=0: everything holds.
- RUN, stop=1: →IDLE, st/sd/step_cnt hold for inspection. Stop beats step_en.
- start in RUN is ignored. cfg_valid in RUN stalls (not accepted, no table change).
- ERR is sticky. clear=1 →IDLE, err_code<=0; table and mask keep their values. start/stop ignored in ERR.
- res mid-run or mid-load: immediate return to reset values next edge; mask cleared, so a reload is required.
- Latency: one cycle from a qualified step to the new st/sd. Read path combinational from table.

Decomposition:
- Package fsm_table_pkg:
  - ctrl_t enum {IDLE, LOAD, RUN, ERR}
  - err_t enum {E_NONE, E_NOT_LOADED, E_ILLEGAL}
  - ADDR_W=4, ENTRY_W=6, STATE_W=3
  - field slice constants NEXT_MSB/LSB, OUT_MSB/LSB
- Sub-module fsm_table_mem: 16xENTRY_W register file, one synchronous write port, one asynchronous read port, no reset.

Test Plan:
- Load table where out=current state, (st,a)→next: 2→6, 5→4, 7→5, 4/a0→2, 4/a1→6, 6/a0→5, 6/a1→7; unused 0,1,3→2. Then start, a=0, 4 steps → st sequence 6,5,4,2; step_cnt=4.
- Same table, a=1, 6 steps from 2 → st 6,7,5,4,6,7; sd sequence 2,6,7,5,4,6.
- start after only 15 writes → err=1, err_code=1, busy=0, cfg_ready=0. clear → IDLE. 16th write then start → busy=1, st=2.
- Rewrite entry addr 4'h2 with next=3, start, step → err_code=2, st stays 2, step_cnt=0. Verify stop/start ignored until clear.
- Corner cases:
  - start with the final write in the same cycle → ERR(1).
  - start and stop together in IDLE → stays IDLE.
  - cfg_valid held during RUN → cfg_ready=0, table unchanged after stop.
  - step_en and stop together → no step.
- res=1 mid-run after 3 steps → st=2, sd=0, step_cnt=0, loaded=0 next cycle. 255+2 steps with CNT_W=8 → step_cnt saturates at 255.
